// File: rtl/mem_access.sv
// mem_access: memory-access stage; aligns stores, runs the data-memory handshake with timeout, registers writeback payload
module mem_access #(
  parameter int TIMEOUT_CYC  = 16,
  parameter int CPU_WIDTH    = 32,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid_i,
  output logic                    ready_o,
  input  logic                    ex_mem_rd_i,
  input  logic                    ex_mem_wr_i,
  input  logic [FUNCT3_WIDTH-1:0] ex_funct3_i,
  input  logic [CPU_WIDTH-1:0]    ex_mem_addr_i,
  input  logic [CPU_WIDTH-1:0]    ex_store_data_i,
  input  logic [CPU_WIDTH-1:0]    ex_reg_wr_data_i,
  input  logic [4:0]              ex_rd_addr_i,
  input  logic                    ex_reg_wr_en_i,
  output logic                    dm_req_o,
  output logic                    dm_we_o,
  output logic [CPU_WIDTH-1:0]    dm_addr_o,
  output logic [CPU_WIDTH-1:0]    dm_wdata_o,
  output logic [3:0]              dm_be_o,
  input  logic                    dm_ack_i,
  input  logic [CPU_WIDTH-1:0]    dm_rdata_i,
  output logic                    wb_valid_o,
  output logic [CPU_WIDTH-1:0]    wb_reg_wr_data_o,
  output logic [CPU_WIDTH-1:0]    data_mem_data_o,
  output logic                    no_writing_mem_o,
  output logic [FUNCT3_WIDTH-1:0] funct3_o,
  output logic [1:0]              mem_addr_index_o,
  output logic [4:0]              rd_addr_o,
  output logic                    reg_wr_en_o,
  output logic                    misalign_o,
  output logic                    bus_err_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req_q, req_d, we_q, we_d;
  logic [CPU_WIDTH-1:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
  logic [CPU_WIDTH-1:0]    wb_data_q, wb_data_d, dmd_q, dmd_d;
  logic                    nwm_q, nwm_d, regwe_q, regwe_d;
  logic [FUNCT3_WIDTH-1:0] f3_q, f3_d;
  logic [1:0]              idx_q, idx_d;
  logic [4:0]              rd_q, rd_d;
  logic [1:0]              idx, sz;
  logic                    mem_op, mis, accept, busy, ack, tmo, fire;
  logic [3:0]              be;
  logic [CPU_WIDTH-1:0]    wd;
  // decode access width, misalignment, lane enables and replicated store data
  always_comb begin
    idx    = ex_mem_addr_i[1:0];
    sz     = ex_funct3_i[1:0];
    mem_op = ex_mem_rd_i | ex_mem_wr_i;
    mis    = mem_op & (sz == 2'b01 ? idx[0] : sz == 2'b10 ? |idx : 1'b0);
    be     = sz == 2'b00 ? 4'b0001 << idx : sz == 2'b01 ? (idx[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd     = !ex_mem_wr_i ? '0 : sz == 2'b00 ? {4{ex_store_data_i[7:0]}} :
             sz == 2'b01 ? {2{ex_store_data_i[15:0]}} : ex_store_data_i;
    accept = ex_valid_i & (state_q == IDLE);
    busy   = state_q == BUSY;
    ack    = busy & dm_ack_i;
    tmo    = busy & !dm_ack_i & (cnt_q == 8'(TIMEOUT_CYC - 1));
    fire   = (accept & (!mem_op | mis)) | ack | tmo;
  end
  // next-state logic; execute holds its inputs while busy, so writeback payload is taken from them at completion
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    valid_d   = fire;
    mis_d     = accept & mis;
    berr_d    = tmo;
    wb_data_d = fire ? ex_reg_wr_data_i : wb_data_q;
    f3_d      = fire ? ex_funct3_i : f3_q;
    idx_d     = fire ? idx : idx_q;
    rd_d      = fire ? ex_rd_addr_i : rd_q;
    nwm_d     = fire ? ex_mem_rd_i : nwm_q;
    regwe_d   = fire ? ex_reg_wr_en_i & !ex_mem_wr_i & !mis & !tmo : regwe_q;
    dmd_d     = ack & ex_mem_rd_i ? dm_rdata_i : dmd_q;
    if (accept & mem_op & !mis) begin
      state_d = BUSY;
      cnt_d   = '0;
      req_d   = 1'b1;
      we_d    = ex_mem_wr_i;
      addr_d  = {ex_mem_addr_i[CPU_WIDTH-1:2], 2'b00};
      be_d    = be;
      wdata_d = wd;
    end else if (ack | tmo) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else if (busy) begin
      cnt_d   = cnt_q + 8'd1;
    end
  end
  // single register bank for FSM state, bus outputs and writeback payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      wb_data_q <= '0;
      dmd_q     <= '0;
      nwm_q     <= 1'b0;
      regwe_q   <= 1'b0;
      f3_q      <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      wb_data_q <= wb_data_d;
      dmd_q     <= dmd_d;
      nwm_q     <= nwm_d;
      regwe_q   <= regwe_d;
      f3_q      <= f3_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
    end
  end
  assign ready_o          = state_q == IDLE;
  assign dm_req_o         = req_q;
  assign dm_we_o          = we_q;
  assign dm_addr_o        = addr_q;
  assign dm_be_o          = be_q;
  assign dm_wdata_o       = wdata_q;
  assign wb_valid_o       = valid_q;
  assign misalign_o       = mis_q;
  assign bus_err_o        = berr_q;
  assign wb_reg_wr_data_o = wb_data_q;
  assign data_mem_data_o  = dmd_q;
  assign no_writing_mem_o = nwm_q;
  assign reg_wr_en_o      = regwe_q;
  assign funct3_o         = f3_q;
  assign mem_addr_index_o = idx_q;
  assign rd_addr_o        = rd_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a behavioural access model
module tb_mem_access;
  localparam int TMO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid_i = 0, ready_o, ex_mem_rd_i = 0, ex_mem_wr_i = 0;
  logic [2:0]  ex_funct3_i = 0, funct3_o;
  logic [31:0] ex_mem_addr_i = 0, ex_store_data_i = 0, ex_reg_wr_data_i = 0;
  logic [4:0]  ex_rd_addr_i = 0, rd_addr_o;
  logic        ex_reg_wr_en_i = 0;
  logic        dm_req_o, dm_we_o, dm_ack_i = 0;
  logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i = 0;
  logic [3:0]  dm_be_o;
  logic        wb_valid_o, no_writing_mem_o, reg_wr_en_o, misalign_o, bus_err_o;
  logic [31:0] wb_reg_wr_data_o, data_mem_data_o;
  logic [1:0]  mem_addr_index_o;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_dmd = 0;
  mem_access #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ready_o(ready_o),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_wr_i(ex_mem_wr_i), .ex_funct3_i(ex_funct3_i),
    .ex_mem_addr_i(ex_mem_addr_i), .ex_store_data_i(ex_store_data_i),
    .ex_reg_wr_data_i(ex_reg_wr_data_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_reg_wr_en_i(ex_reg_wr_en_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_be_o(dm_be_o),
    .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_reg_wr_data_o(wb_reg_wr_data_o), .data_mem_data_o(data_mem_data_o),
    .no_writing_mem_o(no_writing_mem_o), .funct3_o(funct3_o),
    .mem_addr_index_o(mem_addr_index_o), .rd_addr_o(rd_addr_o),
    .reg_wr_en_o(reg_wr_en_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one complete operation; ack_at = number of wait cycles before ack (>= TMO means no ack)
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] alu, input logic [4:0] rdn,
                        input bit wen, input int ack_at, input logic [31:0] rdata);
    int bytes, sh, b, reqc;
    bit mem, mis, ok;
    logic [3:0] ebe;
    logic [31:0] ewd;
    bytes = 1 << f3[1:0];
    mem = rd | wr;
    mis = mem && (int'(addr[1:0]) % bytes != 0);
    sh = int'(addr[1:0]) & (4 - bytes);
    ebe = 4'(((1 << bytes) - 1) << sh);
    for (int k = 0; k < 4; k++) ewd[k*8 +: 8] = wr ? sdata[(k % bytes)*8 +: 8] : 8'h00;
    chk("ready_before", {31'b0, ready_o}, 1);
    ex_valid_i = 1; ex_mem_rd_i = rd; ex_mem_wr_i = wr; ex_funct3_i = f3; ex_mem_addr_i = addr;
    ex_store_data_i = sdata; ex_reg_wr_data_i = alu; ex_rd_addr_i = rdn; ex_reg_wr_en_i = wen;
    tick;
    ex_valid_i = 0;
    ok = 1;
    if (mem && !mis) begin
      chk("dm_req", {31'b0, dm_req_o}, 1);
      chk("dm_we", {31'b0, dm_we_o}, {31'b0, wr});
      chk("dm_addr", dm_addr_o, addr & ~32'd3);
      chk("dm_be", {28'b0, dm_be_o}, {28'b0, ebe});
      chk("dm_wdata", dm_wdata_o, ewd);
      chk("ready_busy", {31'b0, ready_o}, 0);
      b = 0; reqc = 0;
      while (!wb_valid_o && b <= TMO + 2) begin
        if (dm_req_o) reqc++;
        dm_ack_i = (b == ack_at);
        dm_rdata_i = (b == ack_at) ? rdata : $urandom;
        tick;
        dm_ack_i = 0;
        b++;
      end
      ok = ack_at < TMO;
      chk("req_cycles", reqc, ok ? ack_at + 1 : TMO);
      if (ok && rd) exp_dmd = rdata;
    end else begin
      chk("no_req", {31'b0, dm_req_o}, 0);
    end
    chk("wb_valid", {31'b0, wb_valid_o}, 1);
    chk("ready_done", {31'b0, ready_o}, 1);
    chk("dm_req_done", {31'b0, dm_req_o}, 0);
    chk("misalign", {31'b0, misalign_o}, {31'b0, mis});
    chk("bus_err", {31'b0, bus_err_o}, {31'b0, !ok});
    chk("reg_wr_en", {31'b0, reg_wr_en_o}, {31'b0, wen && !wr && !mis && ok});
    chk("wb_data", wb_reg_wr_data_o, alu);
    chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, rdn});
    chk("no_wr_mem", {31'b0, no_writing_mem_o}, {31'b0, rd});
    chk("dm_data", data_mem_data_o, exp_dmd);
    if (mem) begin
      chk("funct3", {29'b0, funct3_o}, {29'b0, f3});
      chk("index", {30'b0, mem_addr_index_o}, {30'b0, addr[1:0]});
    end
    tick;
    chk("wb_pulse", {31'b0, wb_valid_o}, 0);
    chk("exc_pulse", {30'b0, misalign_o, bus_err_o}, 0);
  endtask
  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};
    #12;
    chk("rst_ready", {31'b0, ready_o}, 1);
    chk("rst_bus", {29'b0, dm_req_o, dm_we_o, |dm_be_o}, 0);
    chk("rst_addr_wdata", dm_addr_o | dm_wdata_o, 0);
    chk("rst_wb", {26'b0, wb_valid_o, misalign_o, bus_err_o, reg_wr_en_o, no_writing_mem_o, |rd_addr_o}, 0);
    chk("rst_payload", wb_reg_wr_data_o | data_mem_data_o, 0);
    @(negedge clk) rst_n = 1;
    tick;
    run_op(0, 0, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1, 0, 0);
    run_op(0, 1, 3'd0, 32'h103, 32'hAB, 32'h55, 5'd7, 1, 3, 0);
    run_op(1, 0, 3'd1, 32'h206, 32'h0, 32'h66, 5'd9, 1, 0, 32'hBEEF_0000);
    run_op(1, 0, 3'd2, 32'h301, 32'h0, 32'h77, 5'd3, 1, 0, 0);
    run_op(1, 0, 3'd2, 32'h400, 32'h0, 32'h88, 5'd4, 1, 20, 32'hDEAD_BEEF);
    run_op(1, 0, 3'd2, 32'h404, 32'h0, 32'h99, 5'd4, 1, TMO - 1, 32'hCAFE_F00D);
    run_op(0, 1, 3'd2, 32'h500, 32'h1122_3344, 32'h0, 5'd1, 1, TMO, 0);
    dm_ack_i = 1; dm_rdata_i = 32'hFFFF_FFFF;
    tick;
    dm_ack_i = 0;
    chk("idle_ack_wb", {31'b0, wb_valid_o}, 0);
    chk("idle_ack_ready", {31'b0, ready_o}, 1);
    chk("idle_ack_dmd", data_mem_data_o, exp_dmd);
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2, kind == 1 ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)],
             $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, TMO + 1), $urandom);
    end
    ex_valid_i = 1; ex_mem_rd_i = 1; ex_mem_wr_i = 0; ex_funct3_i = 3'd2; ex_mem_addr_i = 32'h600;
    tick;
    ex_valid_i = 0;
    tick;
    chk("pre_rst_req", {31'b0, dm_req_o}, 1);
    rst_n = 0;
    #1;
    chk("rst_async_req", {31'b0, dm_req_o}, 0);
    chk("rst_async_ready", {31'b0, ready_o}, 1);
    #10 rst_n = 1;
    exp_dmd = 0;
    tick;
    chk("post_rst_wb", {31'b0, wb_valid_o}, 0);
    chk("post_rst_ready", {31'b0, ready_o}, 1);
    chk("post_rst_req", {31'b0, dm_req_o}, 0);
    run_op(0, 0, 3'd0, 32'h0, 32'h0, 32'hA5A5_5A5A, 5'd2, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
